// File: rtl/arm_pipe_pkg.sv
// Shared constants for the ARM core inter-stage pipeline registers.
package arm_pipe_pkg;

  // Control-field bit positions used by the stage wrappers.
  localparam int unsigned CTRL_WB_EN   = 0;
  localparam int unsigned CTRL_MEM_R   = 1;
  localparam int unsigned CTRL_MEM_W   = 2;
  localparam int unsigned CTRL_B       = 3;
  localparam int unsigned CTRL_S       = 4;
  localparam int unsigned CTRL_CMD_LSB = 5;
  localparam int unsigned CTRL_CMD_W   = 4;

  // Occupancy counter width: at most two entries (main + skid).
  localparam int unsigned OCC_W = 2;

  // Per-stage field widths.
  localparam int unsigned IF_ID_CTRL_W   = 1;
  localparam int unsigned IF_ID_DATA_W   = 64;
  localparam int unsigned ID_EXE_CTRL_W  = CTRL_CMD_LSB + CTRL_CMD_W;
  localparam int unsigned ID_EXE_DATA_W  = 128;
  localparam int unsigned EXE_MEM_CTRL_W = 3;
  localparam int unsigned EXE_MEM_DATA_W = 80;
  localparam int unsigned MEM_WB_CTRL_W  = 1;
  localparam int unsigned MEM_WB_DATA_W  = 40;

  // Build an ID/EXE control field from its named parts.
  function automatic logic [ID_EXE_CTRL_W-1:0] pack_id_exe_ctrl(
    input logic       wb_en,
    input logic       mem_r,
    input logic       mem_w,
    input logic       b,
    input logic       s,
    input logic [3:0] cmd
  );
    logic [ID_EXE_CTRL_W-1:0] c;
    c = '0;
    c[CTRL_WB_EN] = wb_en;
    c[CTRL_MEM_R] = mem_r;
    c[CTRL_MEM_W] = mem_w;
    c[CTRL_B]     = b;
    c[CTRL_S]     = s;
    c[CTRL_CMD_LSB +: CTRL_CMD_W] = cmd;
    return c;
  endfunction

endpackage

// File: rtl/arm_pipe_slot.sv
// One pipeline entry: valid flag, control field and payload.
// An empty slot always carries a zero control field so it acts as a NOP.
module arm_pipe_slot #(
  parameter int unsigned CTRL_W   = 8,
  parameter int unsigned DATA_W   = 128,
  parameter bit          CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              wipe,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Entry register; clear beats load, wipe additionally zeroes payload when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLR_DATA && wipe) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrl_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/arm_pipe_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// optional skid entry and a saturating stall counter.
module arm_pipe_stage
  import arm_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W   = 8,
  parameter int unsigned DATA_W   = 128,
  parameter bit          SKID     = 1'b1,
  parameter bit          CLR_DATA = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              acc, pop;
  logic              main_load, main_clear;

  assign pop      = main_v && out_ready;
  // With a skid entry in_ready depends only on state; without it, it looks through out_ready.
  assign in_ready = SKID ? !skid_v : (!main_v || out_ready);
  assign acc      = in_valid && in_ready;

  // Main-entry update. skid_v is tied low without a skid, so the same rule covers both builds.
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
    end else if (!main_v || pop) begin
      if (skid_v || acc) main_load = 1'b1;
      else               main_clear = 1'b1;
    end
  end

  arm_pipe_slot #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CLR_DATA(CLR_DATA)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .wipe   (flush),
    .ctrl_in(skid_v ? skid_ctrl : in_ctrl),
    .data_in(skid_v ? skid_data : in_data),
    .valid  (main_v),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  if (SKID) begin : g_skid
    // Skid catches an input that arrives while main is stalled; it drains first on pop.
    arm_pipe_slot #(
      .CTRL_W  (CTRL_W),
      .DATA_W  (DATA_W),
      .CLR_DATA(CLR_DATA)
    ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (!flush && acc && main_v && !pop && !skid_v),
      .clear  (flush || (skid_v && pop)),
      .wipe   (flush),
      .ctrl_in(in_ctrl),
      .data_in(in_data),
      .valid  (skid_v),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );
  end else begin : g_no_skid
    assign skid_v    = 1'b0;
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end

  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // Saturating count of stalled cycles; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
